// File: rtl/dma_read_logic_if.sv
// ============================================================================
// Module      : dma_read_logic_if
// Description : Signal bundle for the DMA read channel. It carries the
//               control registers, the RAM/arbiter bus and the
//               peripheral-side FIFO push port.
//               The master modport is the DMA read engine. The slave modport
//               is the surrounding system: register file, arbiter, RAM and
//               FIFO.
// Ports       : ctrl_sig_reg, addr_reg, count_reg   control registers
//               mem_request, mem_grant              arbiter handshake
//               mem_addr, mem_rd_enable, mem_rd_data RAM read port
//               full, wr_enable, wr_data            FIFO push port
//               tx_done                             sticky completion flag
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dma_read_logic_if;
    logic [31:0] ctrl_sig_reg;
    logic [31:0] addr_reg;
    logic [31:0] count_reg;
    logic        mem_request;
    logic        mem_grant;
    logic [31:0] mem_addr;
    logic        mem_rd_enable;
    logic [31:0] mem_rd_data;
    logic        full;
    logic        wr_enable;
    logic [31:0] wr_data;
    logic        tx_done;

    modport master (
        input  ctrl_sig_reg, addr_reg, count_reg, mem_grant, mem_rd_data, full,
        output mem_request, mem_addr, mem_rd_enable, wr_enable, wr_data, tx_done
    );

    modport slave (
        output ctrl_sig_reg, addr_reg, count_reg, mem_grant, mem_rd_data, full,
        input  mem_request, mem_addr, mem_rd_enable, wr_enable, wr_data, tx_done
    );
endinterface

`default_nettype wire

// File: rtl/dma_read_logic.sv
// ============================================================================
// Module      : dma_read_logic
// Description : DMA read channel. It fetches count_reg words from RAM
//               through the bus arbiter and pushes them, in order, into the
//               peripheral FIFO.
//               The source address is either fixed or advances by ADDR_STEP
//               per word. A sticky tx_done flag is raised on completion.
// Ports       : clk    single clock, all state changes on posedge
//               reset  asynchronous active-high reset
//               bus    dma_read_logic_if.master (control, RAM bus, FIFO port)
// Parameters  : RD_LATENCY  cycles from read strobe to valid read data (>=1)
//               ADDR_STEP   source address increment when ctrl bit2 = 1
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dma_read_logic #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    dma_read_logic_if.master  bus
);

    localparam int unsigned LAT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY);
    localparam logic [31:0]      STEP     = 32'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUS_REQ = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_PUSH    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_q,     state_d;
    logic [31:0]       cur_addr_q,  cur_addr_d;
    logic [31:0]       cur_count_q, cur_count_d;
    logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
    logic [31:0]       data_buf_q,  data_buf_d;
    logic              tx_done_q,   tx_done_d;

    logic        w_active;
    logic        w_mode;
    logic        w_inc;
    logic        w_abort;

    logic        w_mem_request;
    logic [31:0] w_mem_addr;
    logic        w_mem_rd_enable;
    logic        w_wr_enable;
    logic [31:0] w_wr_data;
    logic        w_tx_done;

    assign w_active = bus.ctrl_sig_reg[0];
    assign w_mode   = bus.ctrl_sig_reg[1];
    assign w_inc    = bus.ctrl_sig_reg[2];

    // Losing dma_active or switching to write mode cancels any transfer in
    // progress. The outputs are gated in that same cycle, so a pending push
    // or strobe never escapes.
    assign w_abort  = (state_q != S_IDLE) && (!w_active || w_mode);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            cur_count_q <= '0;
            lat_cnt_q   <= '0;
            data_buf_q  <= '0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_count_q <= cur_count_d;
            lat_cnt_q   <= lat_cnt_d;
            data_buf_q  <= data_buf_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        cur_count_d     = cur_count_q;
        lat_cnt_d       = lat_cnt_q;
        data_buf_d      = data_buf_q;
        tx_done_d       = tx_done_q;

        w_mem_request   = 1'b0;
        w_mem_addr      = '0;
        w_mem_rd_enable = 1'b0;
        w_wr_enable     = 1'b0;
        w_wr_data       = '0;
        w_tx_done       = tx_done_q;

        if (w_abort) begin
            // An in-flight word is simply left in data_buf_q; it is never
            // pushed because the next start reloads everything.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // tx_done holds until software drops dma_active. This
                    // keeps a still-set bit0 from launching a second run.
                    if (!w_active) begin
                        tx_done_d = 1'b0;
                    end
                    if (w_active && !w_mode && !tx_done_q) begin
                        cur_addr_d  = bus.addr_reg;
                        cur_count_d = bus.count_reg;
                        state_d     = (bus.count_reg == 32'd0) ? S_DONE : S_BUS_REQ;
                    end
                end

                S_BUS_REQ: begin
                    w_mem_request = 1'b1;
                    if (bus.mem_grant) begin
                        state_d = S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    w_mem_request = 1'b1;
                    if (bus.mem_grant) begin
                        w_mem_rd_enable = 1'b1;
                        w_mem_addr      = cur_addr_q;
                        lat_cnt_d       = LAT_LOAD;
                        state_d         = S_WAIT;
                    end
                end

                S_WAIT: begin
                    // The read is already in flight, so the bus stays
                    // requested and grant is not re-examined here.
                    w_mem_request = 1'b1;
                    lat_cnt_d     = lat_cnt_q - 1'b1;
                    if (lat_cnt_q == LAT_W'(1)) begin
                        data_buf_d = bus.mem_rd_data;
                        state_d    = S_PUSH;
                    end
                end

                S_PUSH: begin
                    w_mem_request = 1'b1;
                    if (!bus.full) begin
                        w_wr_enable = 1'b1;
                        w_wr_data   = data_buf_q;
                        if (cur_count_q != 32'd0) begin
                            cur_count_d = cur_count_q - 32'd1;
                        end
                        if (w_inc) begin
                            // Natural 32-bit wrap of the source address.
                            cur_addr_d = cur_addr_q + STEP;
                        end
                        state_d = (cur_count_q <= 32'd1) ? S_DONE : S_ISSUE;
                    end
                end

                S_DONE: begin
                    // The flag is visible in this cycle already. It is then
                    // held by tx_done_q.
                    w_tx_done = 1'b1;
                    tx_done_d = 1'b1;
                    state_d   = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_request   = w_mem_request;
    assign bus.mem_addr      = w_mem_addr;
    assign bus.mem_rd_enable = w_mem_rd_enable;
    assign bus.wr_enable     = w_wr_enable;
    assign bus.wr_data       = w_wr_data;
    assign bus.tx_done       = w_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_dma_read_logic.sv
// ============================================================================
// Module      : tb_dma_read_logic
// Description : Self-checking bench for dma_read_logic. It drives two
//               instances: one with RD_LATENCY=1 and one with RD_LATENCY=3.
//               Each instance is paired with a RAM model whose data follows
//               the address.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dma_read_logic;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_read_logic_if bus();
    dma_read_logic_if bus3();

    dma_read_logic #(.RD_LATENCY(1), .ADDR_STEP(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dma_read_logic #(.RD_LATENCY(3), .ADDR_STEP(4)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // RAM models: data for a strobed address appears exactly RD_LATENCY
    // cycles later. At any other time they return junk.
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= bus.mem_rd_enable ? mem_word(bus.mem_addr) : (32'hBAD0_0000 | 32'(cyc));
        pipe3[0] <= bus3.mem_rd_enable ? mem_word(bus3.mem_addr) : (32'hBAD1_0000 | 32'(cyc));
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus.mem_rd_data  = pipe1;
    assign bus3.mem_rd_data = pipe3[2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr[$], exp_data[$], exp3_addr[$], exp3_data[$];
    int rd_log[$], wr_log[$], rd3_log[$], wr3_log[$];
    int done_cyc;
    logic prev_done;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] addr;
        logic [31:0] count;
        int          exp_rd;
        int          exp_wr;
        logic        exp_done;
        int          exp_gap;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (bus.tx_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pushes(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (wr_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_exp(input logic [31:0] base, input int n, input bit inc);
        logic [31:0] a;
        a = base;
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
            if (inc) a = a + 32'd4;
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        bit ok;
        int t;
        int c7;

        reset     = 1'b1;
        prev_done = 1'b0;
        done_cyc  = -1;
        bus.ctrl_sig_reg  = 32'h5;  bus.addr_reg  = 32'h100; bus.count_reg  = 32'd4;
        bus.mem_grant     = 1'b1;   bus.full      = 1'b0;
        bus3.ctrl_sig_reg = 32'h5;  bus3.addr_reg = 32'h100; bus3.count_reg = 32'd4;
        bus3.mem_grant    = 1'b1;   bus3.full     = 1'b0;

        vecs[0] = '{32'h5, 32'h0000_0100, 32'd4, 4, 4, 1'b1, 3};
        vecs[1] = '{32'h1, 32'h0000_0200, 32'd3, 3, 3, 1'b1, 3};
        vecs[2] = '{32'h5, 32'h0000_1000, 32'd1, 1, 1, 1'b1, 0};
        vecs[3] = '{32'h7, 32'h0000_0300, 32'd2, 0, 0, 1'b0, 0};
        vecs[4] = '{32'h5, 32'hFFFF_FFF8, 32'd3, 3, 3, 1'b1, 3};

        // Monitor: scoreboards the reads and pushes of both instances.
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (bus.mem_rd_enable) begin
                        rd_log.push_back(cyc);
                        if (exp_addr.size() == 0) fail_now("unexpected read strobe");
                        else check("read addr", bus.mem_addr, exp_addr.pop_front());
                    end else begin
                        check("idle mem_addr", bus.mem_addr, 32'h0);
                    end
                    if (bus.wr_enable) begin
                        wr_log.push_back(cyc);
                        if (exp_data.size() == 0) fail_now("unexpected push");
                        else check("push data", bus.wr_data, exp_data.pop_front());
                    end else begin
                        check("idle wr_data", bus.wr_data, 32'h0);
                    end
                    if (bus.tx_done && !prev_done) done_cyc = cyc;
                    prev_done = bus.tx_done;

                    if (bus3.mem_rd_enable) begin
                        rd3_log.push_back(cyc);
                        if (exp3_addr.size() == 0) fail_now("L3 unexpected read strobe");
                        else check("L3 read addr", bus3.mem_addr, exp3_addr.pop_front());
                    end
                    if (bus3.wr_enable) begin
                        wr3_log.push_back(cyc);
                        if (exp3_data.size() == 0) fail_now("L3 unexpected push");
                        else check("L3 push data", bus3.wr_data, exp3_data.pop_front());
                    end
                end
            end
        join_none

        // ---------------- reset state ----------------
        repeat (3) step();
        @(negedge clk);
        check("rst mem_request",   bus.mem_request,   32'h0);
        check("rst mem_rd_enable", bus.mem_rd_enable, 32'h0);
        check("rst mem_addr",      bus.mem_addr,      32'h0);
        check("rst wr_enable",     bus.wr_enable,     32'h0);
        check("rst wr_data",       bus.wr_data,       32'h0);
        check("rst tx_done",       bus.tx_done,       32'h0);
        check("rst L3 mem_request", bus3.mem_request, 32'h0);
        bus.ctrl_sig_reg  = 32'h0;
        bus3.ctrl_sig_reg = 32'h0;
        step();
        reset = 1'b0;
        step();

        // ---------------- table-driven transfers ----------------
        for (int v = 0; v < 5; v++) begin
            clear_logs();
            done_cyc = -1;
            load_exp(vecs[v].addr, vecs[v].exp_rd, vecs[v].ctrl[2]);
            bus.addr_reg     = vecs[v].addr;
            bus.count_reg    = vecs[v].count;
            bus.ctrl_sig_reg = vecs[v].ctrl;
            if (vecs[v].exp_done) begin
                wait_done(200, ok);
                check($sformatf("vec%0d done seen", v), 32'(ok), 32'h1);
            end else begin
                repeat (20) step();
            end
            repeat (3) step();
            check($sformatf("vec%0d tx_done held", v), bus.tx_done, 32'(vecs[v].exp_done));
            check($sformatf("vec%0d reads", v),  rd_log.size(), vecs[v].exp_rd);
            check($sformatf("vec%0d pushes", v), wr_log.size(), vecs[v].exp_wr);
            check($sformatf("vec%0d leftover", v), exp_data.size(), 32'h0);
            if (vecs[v].exp_gap != 0 && wr_log.size() == vecs[v].exp_wr) begin
                for (int i = 1; i < wr_log.size(); i++)
                    check($sformatf("vec%0d push gap", v), wr_log[i] - wr_log[i-1], vecs[v].exp_gap);
                check($sformatf("vec%0d done latency", v), done_cyc, wr_log[wr_log.size()-1] + 1);
            end
            bus.ctrl_sig_reg = 32'h0;
            step();
            step();
            check($sformatf("vec%0d tx_done cleared", v), bus.tx_done, 32'h0);
        end

        // ---------------- FIFO full on the second push ----------------
        clear_logs();
        load_exp(32'h100, 4, 1'b1);
        bus.addr_reg = 32'h100; bus.count_reg = 32'd4; bus.ctrl_sig_reg = 32'h5;
        wait_pushes(1, 50, ok);
        check("stall first push seen", 32'(ok), 32'h1);
        t = wr_log[0];
        bus.full = 1'b1;
        repeat (7) step();
        check("stall no push while full", wr_log.size(), 32'd1);
        check("stall no read while full", rd_log.size(), 32'd2);
        bus.full = 1'b0;
        wait_done(100, ok);
        check("stall done seen", 32'(ok), 32'h1);
        check("stall total pushes", wr_log.size(), 32'd4);
        if (wr_log.size() > 1) check("stall release push cycle", wr_log[1], t + 8);
        if (rd_log.size() > 2) check("stall next read cycle", rd_log[2], t + 9);
        check("stall leftover", exp_data.size(), 32'h0);
        bus.ctrl_sig_reg = 32'h0;
        step(); step();

        // ---------------- grant delayed, then dropped at ISSUE ----------------
        clear_logs();
        load_exp(32'h400, 2, 1'b1);
        bus.mem_grant = 1'b0;
        bus.addr_reg = 32'h400; bus.count_reg = 32'd2; bus.ctrl_sig_reg = 32'h5;
        for (int i = 0; i < 3; i++) begin
            step();
            check("gnt wait request", bus.mem_request, 32'h1);
            check("gnt wait no strobe", bus.mem_rd_enable, 32'h0);
        end
        step();
        bus.mem_grant = 1'b1;
        check("gnt bus_req request", bus.mem_request, 32'h1);
        for (int i = 0; i < 2; i++) begin
            step();
            bus.mem_grant = 1'b0;
            #1;
            check("gnt issue request", bus.mem_request, 32'h1);
            check("gnt issue no strobe", bus.mem_rd_enable, 32'h0);
        end
        step();
        c7 = cyc;
        bus.mem_grant = 1'b1;
        #1;
        check("gnt strobe on grant", bus.mem_rd_enable, 32'h1);
        check("gnt strobe addr", bus.mem_addr, 32'h400);
        wait_done(100, ok);
        check("gnt done seen", 32'(ok), 32'h1);
        check("gnt pushes", wr_log.size(), 32'd2);
        if (rd_log.size() > 0) check("gnt first read cycle", rd_log[0], c7);
        bus.ctrl_sig_reg = 32'h0;
        step(); step();

        // ---------------- abort after the second push ----------------
        clear_logs();
        load_exp(32'h500, 8, 1'b1);
        bus.addr_reg = 32'h500; bus.count_reg = 32'd8; bus.ctrl_sig_reg = 32'h5;
        wait_pushes(2, 50, ok);
        check("abort two pushes seen", 32'(ok), 32'h1);
        bus.ctrl_sig_reg = 32'h4;
        #1;
        check("abort request drop", bus.mem_request, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("abort request low", bus.mem_request, 32'h0);
            check("abort tx_done low", bus.tx_done, 32'h0);
        end
        check("abort pushes", wr_log.size(), 32'd2);
        check("abort reads", rd_log.size(), 32'd2);
        check("abort words left", exp_data.size(), 32'd6);
        clear_logs();
        bus.ctrl_sig_reg = 32'h0;
        step();

        // ---------------- zero-count transfer ----------------
        clear_logs();
        bus.addr_reg = 32'h600; bus.count_reg = 32'd0; bus.ctrl_sig_reg = 32'h5;
        wait_done(10, ok);
        check("zero done seen", 32'(ok), 32'h1);
        repeat (3) step();
        check("zero reads", rd_log.size(), 32'd0);
        check("zero pushes", wr_log.size(), 32'd0);
        bus.ctrl_sig_reg = 32'h0;
        step(); step();

        // ---------------- RD_LATENCY=3 with address wrap ----------------
        exp3_addr.push_back(32'hFFFF_FFFC); exp3_data.push_back(mem_word(32'hFFFF_FFFC));
        exp3_addr.push_back(32'h0000_0000); exp3_data.push_back(mem_word(32'h0000_0000));
        bus3.addr_reg = 32'hFFFF_FFFC; bus3.count_reg = 32'd2; bus3.ctrl_sig_reg = 32'h5;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus3.tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("L3 done seen", 32'(ok), 32'h1);
        step();
        check("L3 reads", rd3_log.size(), 32'd2);
        check("L3 pushes", wr3_log.size(), 32'd2);
        if (rd3_log.size() == 2 && wr3_log.size() == 2) begin
            check("L3 read spacing", rd3_log[1] - rd3_log[0], 32'd5);
            check("L3 push spacing", wr3_log[1] - wr3_log[0], 32'd5);
            check("L3 strobe to push", wr3_log[0] - rd3_log[0], 32'd4);
        end
        check("L3 leftover", exp3_data.size(), 32'h0);
        bus3.ctrl_sig_reg = 32'h0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
